// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a return-address stack for CALL/RET.
// Overflow or underflow of the stack sets a sticky fault and degrades the op to NEXT.
module pc_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int RAS_DEPTH    = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [2:0]                           op,
  input  logic                                 cond,
  input  logic [15:0]                          C,
  input  logic                                 msel,
  output logic [PC_WIDTH-1:0]                  pc,
  output logic [PC_WIDTH-1:0]                  addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count,
  output logic                                 ras_full,
  output logic                                 ras_empty,
  output logic                                 fault
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_NEXT   = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_VECTOR);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [CNT_W-1:0]    r_count;
  logic                r_fault;

  logic                       w_full;
  logic                       w_empty;
  logic [CNT_W-1:0]           w_cnt_dec;
  logic [IDX_W-1:0]           w_push_idx;
  logic [IDX_W-1:0]           w_pop_idx;
  logic [PC_WIDTH-1:0]        w_pc_inc;
  logic signed [PC_WIDTH-1:0] w_offset;
  logic [PC_WIDTH-1:0]        w_pc_next;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_fault_set;
  logic                       w_unused_c;

  assign w_full     = (r_count == CNT_MAX);
  assign w_empty    = (r_count == '0);
  assign w_cnt_dec  = r_count - CNT_ONE;
  assign w_push_idx = r_count[IDX_W-1:0];
  assign w_pop_idx  = w_cnt_dec[IDX_W-1:0];
  assign w_pc_inc   = r_pc + 1'b1;
  // Two's-complement offset; modulo-2^PC_WIDTH addition discards the carry.
  assign w_offset   = signed'(C[PC_WIDTH-1:0]);
  // Upper C bits carry datapath content that the sequencer ignores.
  assign w_unused_c = ^C;

  always_comb begin
    w_pc_next   = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_fault_set = 1'b0;
    case (op)
      OP_NEXT:   w_pc_next = w_pc_inc;
      OP_JUMP:   w_pc_next = C[PC_WIDTH-1:0];
      OP_BRANCH: w_pc_next = cond ? PC_WIDTH'(w_pc_inc + w_offset) : w_pc_inc;
      OP_CALL: begin
        if (w_full) begin
          w_fault_set = 1'b1;
          w_pc_next   = w_pc_inc;
        end else begin
          w_push    = 1'b1;
          w_pc_next = C[PC_WIDTH-1:0];
        end
      end
      OP_RET: begin
        if (w_empty) begin
          w_fault_set = 1'b1;
          w_pc_next   = w_pc_inc;
        end else begin
          w_pop     = 1'b1;
          w_pc_next = r_stack[w_pop_idx];
        end
      end
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= PC_RST;
      r_count <= '0;
      r_fault <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop) begin
        r_count <= w_cnt_dec;
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  // Stack storage is data only; occupancy in r_count defines validity.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc        = r_pc;
  assign addr      = msel ? C[PC_WIDTH-1:0] : r_pc;
  assign ras_count = r_count;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;
  assign fault     = r_fault;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter and address width (2..16).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (1..16).
REQ-003 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  when high, freezes all state.
REQ-007 SHALL have port op  input  3  operation: 000 HOLD, 001 NEXT, 010 JUMP, 011 BRANCH, 100 CALL, 101 RET; 110 and 111 are treated as HOLD.
REQ-008 SHALL have port cond  input  1  branch condition, used only by BRANCH.
REQ-009 SHALL have port C  input  16  datapath value carrying the jump target or branch offset in C[PC_WIDTH-1:0].
REQ-010 SHALL have port msel  input  1  address-source select for addr.
REQ-011 SHALL have port pc  output  PC_WIDTH  registered program counter.
REQ-012 SHALL have port addr  output  PC_WIDTH  memory address: C[PC_WIDTH-1:0] when msel=1, else pc; combinational.
REQ-013 SHALL have port ras_count  output  clog2(RAS_DEPTH+1)  number of occupied stack entries.
REQ-014 SHALL have port ras_full and ras_empty  outputs  1 each  asserted when ras_count==RAS_DEPTH and ras_count==0 respectively.
REQ-015 SHALL have port fault  output  1  sticky flag for stack overflow or underflow.

Function
REQ-016 SHALL apply priority reset > stall > op on every rising clk edge.
REQ-017 SHALL leave pc, the stack, ras_count and fault unchanged when stall=1 and reset=0, whatever op is.
REQ-018 HOLD SHALL leave pc unchanged.
REQ-019 NEXT SHALL set pc <= pc+1.
REQ-020 JUMP SHALL set pc <= C[PC_WIDTH-1:0].
REQ-021 BRANCH with cond=1 SHALL set pc <= pc + 1 + C[PC_WIDTH-1:0], with the offset treated as two's complement; BRANCH with cond=0 SHALL behave as NEXT.
REQ-022 CALL with ras_full=0 SHALL push pc+1 onto the stack, increment ras_count and set pc <= C[PC_WIDTH-1:0], all in the same cycle.
REQ-023 RET with ras_empty=0 SHALL set pc <= top of stack (last pushed value) and decrement ras_count.
REQ-024 CALL with ras_full=1 SHALL NOT push, SHALL set fault, and SHALL behave as NEXT.
REQ-025 RET with ras_empty=1 SHALL NOT pop, SHALL set fault, and SHALL behave as NEXT.
REQ-026 All PC arithmetic SHALL be modulo 2^PC_WIDTH; pc+1 at all-ones SHALL wrap to 0, and carry-out SHALL be discarded.
REQ-027 The stack SHALL be LIFO, holding PC_WIDTH-bit entries; entries above ras_count SHALL be don't-care.
REQ-028 fault, once set, SHALL remain set until reset; no other op SHALL clear it.
REQ-029 All operations SHALL have single-cycle latency: the new pc is visible in the cycle after the edge that samples op.
REQ-030 addr SHALL follow msel, C and pc combinationally, with no register stage; pc SHALL NOT be affected by msel.
REQ-031 ras_full, ras_empty and ras_count SHALL be derived only from registered state.

Reset
REQ-032 On a rising clk edge with reset=1, SHALL set pc <= RESET_VECTOR, ras_count <= 0 and fault <= 0, regardless of stall and op.
REQ-033 After reset SHALL present ras_empty=1 and ras_full=0; stack contents SHALL be don't-care.
REQ-034 A reset asserted during any sequence, including a CALL/RET chain, SHALL discard the whole stack in that same cycle.

Verification
REQ-035 Reset, then NEXT x3 from RESET_VECTOR=0 -> pc reads 1, 2, 3; ras_empty=1, fault=0.
REQ-036 PC_WIDTH=8: JUMP C=0x00FE, then NEXT x2 -> pc reads 0xFE, 0xFF, 0x00 (wrap).
REQ-037 pc=0x10: BRANCH cond=1 C=0x00FC -> pc=0x0D; BRANCH cond=0 -> pc=0x0E.
REQ-038 pc=0x05: CALL C=0x40, then CALL C=0x80, then RET, then RET -> pc reads 0x40, 0x80, 0x41, 0x06; ras_count reads 1, 2, 1, 0.
REQ-039 RAS_DEPTH=4: 5 consecutive CALLs -> on the 5th, ras_full=1 and fault=1, pc = previous pc+1, and ras_count stays 4; RET on an empty stack -> fault=1 and pc increments.
REQ-040 stall=1 with op=CALL -> pc and ras_count unchanged; reset=1 with stall=1 -> pc=RESET_VECTOR, ras_count=0, fault=0; msel=1 with C=0x0033 -> addr=0x33 and pc unchanged.
